// File: rtl/inv_key_expander_pkg.sv
// Shared AES-128 key-schedule definitions: sizes, FSM states, RotWord and the Rcon table.
package inv_key_expander_pkg;

    localparam int KEY_LEN  = 128;
    localparam int WORD_LEN = 32;
    localparam int NR       = 10;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SUB,
        STEP
    } state_t;

    function automatic logic [31:0] rot_word(input logic [31:0] x);
        return {x[23:0], x[31:24]};
    endfunction

    function automatic logic [31:0] rcon(input logic [3:0] round);
        logic [7:0] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h0};
    endfunction

endpackage

// File: rtl/inv_key_expander_subword.sv
// Registered AES SubWord: four forward S-boxes on a 32-bit word, one cycle of latency.
module inv_key_expander_subword (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] data_in,
    output logic        valid_out,
    output logic [31:0] data_out
);

    logic        r_valid;
    logic [31:0] r_data;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 in GF(2^8) (maps 0 to 0), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_valid <= 1'b0;
        else        r_valid <= valid_in;
    end

    always_ff @(posedge clk) begin
        if (valid_in)
            r_data <= {sbox(data_in[31:24]), sbox(data_in[23:16]),
                       sbox(data_in[15:8]),  sbox(data_in[7:0])};
    end

    assign valid_out = r_valid;
    assign data_out  = r_data;

endmodule

// File: rtl/inv_key_expander.sv
// Iterative AES-128 inverse key schedule: emits round keys 10 down to 0, one per two cycles.
module inv_key_expander #(
    parameter int KEY_LEN  = inv_key_expander_pkg::KEY_LEN,
    parameter int WORD_LEN = inv_key_expander_pkg::WORD_LEN,
    parameter int NR       = inv_key_expander_pkg::NR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [KEY_LEN-1:0] key_in,
    output logic               busy,
    output logic               valid_out,
    output logic [KEY_LEN-1:0] key_out,
    output logic [3:0]         round_out,
    output logic               done
);
    import inv_key_expander_pkg::*;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [KEY_LEN-1:0]  r_kreg;
    logic [3:0]          r_rnd;
    logic                w_step;
    logic                w_sub_vld_in;
    logic                w_sub_vld_out;
    logic [WORD_LEN-1:0] w_sub_in;
    logic [WORD_LEN-1:0] w_sub_out;
    logic [WORD_LEN-1:0] w_w0, w_w1, w_w2, w_w3;
    logic [WORD_LEN-1:0] w_p0, w_p1, w_p2, w_p3;
    logic [KEY_LEN-1:0]  w_prev_key;

    assign w_w0 = r_kreg[KEY_LEN-1 -: WORD_LEN];
    assign w_w1 = r_kreg[3*WORD_LEN-1 -: WORD_LEN];
    assign w_w2 = r_kreg[2*WORD_LEN-1 -: WORD_LEN];
    assign w_w3 = r_kreg[WORD_LEN-1:0];

    // Undo one forward expansion step; Rcon is indexed by the round being undone.
    assign w_p3       = w_w3 ^ w_w2;
    assign w_p2       = w_w2 ^ w_w1;
    assign w_p1       = w_w1 ^ w_w0;
    assign w_sub_in   = rot_word(w_p3);
    assign w_p0       = w_w0 ^ w_sub_out ^ rcon(r_rnd);
    assign w_prev_key = {w_p0, w_p1, w_p2, w_p3};

    inv_key_expander_subword u_subword (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (w_sub_vld_in),
        .data_in   (w_sub_in),
        .valid_out (w_sub_vld_out),
        .data_out  (w_sub_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // STEP waits on the SubWord strobe, so a deeper S-box needs no FSM change.
    always_comb begin
        w_state_nxt  = r_state;
        w_sub_vld_in = 1'b0;
        w_step       = 1'b0;
        valid_out    = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: if (start) w_state_nxt = LOAD;
            LOAD: begin
                valid_out   = 1'b1;
                w_state_nxt = SUB;
            end
            SUB: begin
                w_sub_vld_in = 1'b1;
                w_state_nxt  = STEP;
            end
            STEP: begin
                if (w_sub_vld_out) begin
                    w_step    = 1'b1;
                    valid_out = 1'b1;
                    if (r_rnd == 4'd1) begin
                        done        = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = SUB;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_kreg <= '0;
            r_rnd  <= 4'd0;
        end else if (r_state == IDLE && start) begin
            r_kreg <= key_in;
            r_rnd  <= 4'(NR);
        end else if (w_step) begin
            r_kreg <= w_prev_key;
            r_rnd  <= r_rnd - 4'd1;
        end
    end

    // The new key is presented combinationally on the STEP strobe and held in r_kreg afterwards.
    assign busy      = (r_state != IDLE);
    assign key_out   = w_step ? w_prev_key : r_kreg;
    assign round_out = w_step ? (r_rnd - 4'd1) : r_rnd;

endmodule

// File: tb/tb_inv_key_expander.sv
// Scoreboard bench for inv_key_expander: table-based AES model, forward round-trip and timing checks.
module tb_inv_key_expander;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         valid_out;
    logic [127:0] key_out;
    logic [3:0]   round_out;
    logic         done;

    int cyc   = 0;
    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [127:0] key;
        int           rnd;
        int           cyc;
        logic         dn;
    } exp_t;

    exp_t sb[$];

    logic [127:0] fix9, fix1, fix0;
    bit           fix_en = 0;

    logic [7:0] SBOX [0:255] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    logic [7:0] RC [0:10] = '{8'h00,8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};

    inv_key_expander dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .key_in    (key_in),
        .busy      (busy),
        .valid_out (valid_out),
        .key_out   (key_out),
        .round_out (round_out),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] sub_rot(input logic [31:0] x);
        logic [31:0] r;
        r = {x[23:0], x[31:24]};
        return {SBOX[r[31:24]], SBOX[r[23:16]], SBOX[r[15:8]], SBOX[r[7:0]]};
    endfunction

    function automatic logic [127:0] inv_model(input logic [127:0] k, input int r);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0] ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ sub_rot(p3) ^ {RC[r], 24'h0};
        return {p0, p1, p2, p3};
    endfunction

    function automatic logic [127:0] fwd_model(input logic [127:0] k, input int r);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {RC[r], 24'h0};
        n1 = n0 ^ k[95:64];
        n2 = n1 ^ k[63:32];
        n3 = n2 ^ k[31:0];
        return {n0, n1, n2, n3};
    endfunction

    function automatic void push_seq(input logic [127:0] k, input int c0);
        logic [127:0] keys [0:10];
        exp_t e;
        keys[10] = k;
        for (int r = 10; r >= 1; r--) keys[r-1] = inv_model(keys[r], r);
        if (fix_en) begin
            keys[9] = fix9;
            keys[1] = fix1;
            keys[0] = fix0;
        end
        for (int r = 10; r >= 0; r--) begin
            e.key = keys[r];
            e.rnd = r;
            e.cyc = c0 + 1 + 2 * (10 - r);
            e.dn  = (r == 0);
            sb.push_back(e);
        end
    endfunction

    // Monitor: pops the scoreboard on every strobe and checks hold/spacing between strobes.
    logic [127:0] last_key = '0;
    logic [127:0] prev_key = '0;
    logic [3:0]   prev_rnd = '0;
    bit           prev_vld = 0;
    bit           hold_ok  = 0;

    always @(negedge clk) begin
        exp_t e;
        int   r;
        if (valid_out) begin
            chk("vld_gap", prev_vld, 1'b0);
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {124'd0, round_out}, 128'hFFFF);
            end else begin
                e = sb.pop_front();
                chk("key", key_out, e.key);
                chk("round", round_out, e.rnd);
                chk("strobe_cyc", cyc, e.cyc);
                chk("done", done, e.dn);
            end
            r = int'(round_out);
            if (r < 10) chk("roundtrip", fwd_model(key_out, r + 1), last_key);
            last_key = key_out;
        end else begin
            if (done) chk("done_no_vld", done, 1'b0);
            if (reset && hold_ok) begin
                chk("hold_key", key_out, prev_key);
                chk("hold_rnd", round_out, prev_rnd);
            end
        end
        hold_ok  = reset;
        prev_vld = valid_out;
        prev_key = key_out;
        prev_rnd = round_out;
    end

    task automatic step_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_at(input int c, input logic [127:0] k);
        step_to(c);
        start  = 1'b1;
        key_in = k;
        if (!busy) push_seq(k, cyc);
        @(posedge clk);
        #1;
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (busy || sb.size() != 0); i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_sb", sb.size(), 0);
        chk("drain_busy", busy, 1'b0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_vld"}, valid_out, 1'b0);
        chk({tag, "_key"}, key_out, '0);
        chk({tag, "_rnd"}, round_out, 4'd0);
        chk({tag, "_done"}, done, 1'b0);
    endtask

    initial begin
        int c0;
        reset  = 1'b1;
        start  = 1'b0;
        key_in = '0;
        #2 reset = 1'b0;
        #1 chk_zero_outputs("reset");
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        // Known cipher key schedule, with literal round 9/1/0 values.
        fix9   = 128'hac7766f319fadc2128d12941575c006e;
        fix1   = 128'ha0fafe1788542cb123a339392a6c7605;
        fix0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fix_en = 1;
        start_at(cyc, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        fix_en = 0;
        drain();

        // Start pulses while busy, including the final STEP cycle.
        c0 = cyc + 1;
        start_at(c0, 128'h00112233445566778899aabbccddeeff);
        start_at(c0 + 5, 128'hdeadbeefdeadbeefdeadbeefdeadbeef);
        start_at(c0 + 21, 128'hcafef00dcafef00dcafef00dcafef00d);
        drain();
        repeat (30) @(posedge clk);
        #1 chk("no_second_seq", busy, 1'b0);

        // Back-to-back acceptance in cycle 22.
        c0 = cyc + 1;
        start_at(c0, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);
        start_at(c0 + 22, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        drain();

        // Reset mid-run aborts; a fresh start afterwards runs to completion.
        c0 = cyc + 1;
        start_at(c0, 128'h8e73b0f7da0e6452c810f32b809079e5);
        step_to(c0 + 10);
        reset = 1'b0;
        sb.delete();
        #1 chk_zero_outputs("midrst");
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        start_at(cyc, 128'h8e73b0f7da0e6452c810f32b809079e5);
        drain();

        // Zero key and a random key.
        start_at(cyc, '0);
        drain();
        start_at(cyc, {$urandom, $urandom, $urandom, $urandom});
        drain();

        repeat (4) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
